// File: rtl/cpu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared definitions for the CPU control sequencer: FSM state encoding
// (also exported on the debug state port) and the opcode map.
// ---------------------------------------------------------------------------
package cpu_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_HALT   = 3'd4,
      ST_FAULT  = 3'd5
   } state_t;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_CLA = 4'h2;
   localparam logic [3:0] OP_INC = 4'h3;
   localparam logic [3:0] OP_JMP = 4'h4;
   localparam logic [3:0] OP_JZ  = 4'h5;
   localparam logic [3:0] OP_HLT = 4'hF;

   // Opcodes that retire normally; anything else sends EXEC to FAULT.
   function automatic logic op_known(input logic [3:0] op);
      return (op == OP_NOP) || (op == OP_LDA) || (op == OP_CLA) ||
             (op == OP_INC) || (op == OP_JMP) || (op == OP_JZ)  ||
             (op == OP_HLT);
   endfunction

endpackage

// File: rtl/cpu_ctrl_seq.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_seq
// Control sequencer for a tiny accumulator CPU. Walks FETCH -> DECODE -> EXEC
// per instruction, issues PC / IR / accumulator strobes, times out a stalled
// memory fetch into FAULT, and counts retired instructions.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   start        level; leaves IDLE or HALT for FETCH
//   ir_opcode    opcode from the IR, valid from DECODE onward
//   ac_zero      accumulator is zero (JZ condition)
//   mem_ready    memory returns the instruction word this cycle
//   mem_rd       instruction read request (every FETCH cycle)
//   ir_load      IR load strobe
//   pc_inc       PC increment strobe
//   pc_load      PC jump-load strobe
//   ac_load/ac_inc/ac_clr  accumulator strobes
//   halted/fault status flags decoded from state
//   state        current state encoding (debug)
//   instr_cnt    retired instruction count, wraps 255 -> 0
//
// State table
//   state  | meaning
//   IDLE   | after reset, waiting for start, no strobes
//   FETCH  | mem_rd asserted, waiting for mem_ready (bounded by MAX_WAIT)
//   DECODE | one idle cycle while the IR settles
//   EXEC   | one cycle, opcode-specific strobe, retire
//   HALT   | HLT executed, halted=1, start resumes at FETCH
//   FAULT  | fetch timeout or illegal opcode, held until rst
// ---------------------------------------------------------------------------
module cpu_ctrl_seq
   import cpu_ctrl_pkg::*;
#(
   parameter int OPW      = 4,
   parameter int MAX_WAIT = 15
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [OPW-1:0] ir_opcode,
   input  logic           ac_zero,
   input  logic           mem_ready,
   output logic           mem_rd,
   output logic           ir_load,
   output logic           pc_inc,
   output logic           pc_load,
   output logic           ac_load,
   output logic           ac_inc,
   output logic           ac_clr,
   output logic           halted,
   output logic           fault,
   output logic [2:0]     state,
   output logic [7:0]     instr_cnt
);

   localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

   state_t          r_state;
   state_t          w_next;
   logic [WW-1:0]   r_wait;
   logic [WW-1:0]   w_wait_nxt;
   logic [7:0]      r_instr_cnt;
   logic            w_retire;

   logic            w_mem_rd;
   logic            w_ir_load;
   logic            w_pc_inc;
   logic            w_pc_load;
   logic            w_ac_load;
   logic            w_ac_inc;
   logic            w_ac_clr;

   // Zero-extend so the decode works for any OPW: the low nibble selects the
   // operation and any set bit above it makes the opcode illegal.
   logic [OPW+3:0]  w_op_ext;
   logic [3:0]      w_op4;
   logic            w_op_hi_zero;
   logic            w_op_ok;

   assign w_op_ext     = {4'b0000, ir_opcode};
   assign w_op4        = w_op_ext[3:0];
   assign w_op_hi_zero = ((w_op_ext >> 4) == '0);
   assign w_op_ok      = w_op_hi_zero && op_known(w_op4);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_wait      <= '0;
         r_instr_cnt <= '0;
      end else begin
         r_state <= w_next;
         r_wait  <= w_wait_nxt;
         if (w_retire) begin
            r_instr_cnt <= r_instr_cnt + 8'd1;
         end
      end
   end

   always_comb begin
      w_next     = r_state;
      w_wait_nxt = '0;
      w_retire   = 1'b0;
      w_mem_rd   = 1'b0;
      w_ir_load  = 1'b0;
      w_pc_inc   = 1'b0;
      w_pc_load  = 1'b0;
      w_ac_load  = 1'b0;
      w_ac_inc   = 1'b0;
      w_ac_clr   = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_next = ST_FETCH;
            end
         end

         ST_FETCH: begin
            w_mem_rd = 1'b1;
            if (mem_ready) begin
               w_ir_load = 1'b1;
               w_pc_inc  = 1'b1;
               w_next    = ST_DECODE;
            end else if (r_wait == WW'(MAX_WAIT)) begin
               w_next = ST_FAULT;
            end else begin
               w_wait_nxt = r_wait + WW'(1);
            end
         end

         ST_DECODE: begin
            w_next = ST_EXEC;
         end

         ST_EXEC: begin
            if (!w_op_ok) begin
               w_next = ST_FAULT;
            end else begin
               w_retire = 1'b1;
               w_next   = (w_op4 == OP_HLT) ? ST_HALT : ST_FETCH;
               case (w_op4)
                  OP_LDA:  w_ac_load = 1'b1;
                  OP_CLA:  w_ac_clr  = 1'b1;
                  OP_INC:  w_ac_inc  = 1'b1;
                  OP_JMP:  w_pc_load = 1'b1;
                  OP_JZ:   w_pc_load = ac_zero;
                  default: ;
               endcase
            end
         end

         ST_HALT: begin
            if (start) begin
               w_next = ST_FETCH;
            end
         end

         ST_FAULT: begin
            w_next = ST_FAULT;
         end

         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   // Reset is synchronous, but strobes are masked in the reset cycle itself so
   // an interrupted FETCH/EXEC never leaks a side effect into the datapath.
   assign mem_rd    = w_mem_rd  & ~rst;
   assign ir_load   = w_ir_load & ~rst;
   assign pc_inc    = w_pc_inc  & ~rst;
   assign pc_load   = w_pc_load & ~rst;
   assign ac_load   = w_ac_load & ~rst;
   assign ac_inc    = w_ac_inc  & ~rst;
   assign ac_clr    = w_ac_clr  & ~rst;

   assign halted    = (r_state == ST_HALT);
   assign fault     = (r_state == ST_FAULT);
   assign state     = r_state;
   assign instr_cnt = r_instr_cnt;

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// ---------------------------------------------------------------------------
// tb_cpu_ctrl_seq
// Directed bench for cpu_ctrl_seq. Inputs change 1 ns after the rising edge,
// outputs are sampled 1 ns later. Strobe vector order:
//   {mem_rd, ir_load, pc_inc, pc_load, ac_load, ac_inc, ac_clr}
// ---------------------------------------------------------------------------
module tb_cpu_ctrl_seq;

   localparam logic [6:0] S_NONE  = 7'b0000000;
   localparam logic [6:0] S_FETCH = 7'b1110000;
   localparam logic [6:0] S_WAIT  = 7'b1000000;
   localparam logic [6:0] S_PCL   = 7'b0001000;
   localparam logic [6:0] S_ACL   = 7'b0000100;
   localparam logic [6:0] S_ACI   = 7'b0000010;
   localparam logic [6:0] S_ACC   = 7'b0000001;

   logic       clk;
   logic       rst;
   logic       start;
   logic [3:0] ir_opcode;
   logic       ac_zero;
   logic       mem_ready;
   logic       mem_rd;
   logic       ir_load;
   logic       pc_inc;
   logic       pc_load;
   logic       ac_load;
   logic       ac_inc;
   logic       ac_clr;
   logic       halted;
   logic       fault;
   logic [2:0] state;
   logic [7:0] instr_cnt;

   int total = 0;
   int bad   = 0;

   cpu_ctrl_seq #(.OPW(4), .MAX_WAIT(15)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .ir_opcode (ir_opcode),
      .ac_zero   (ac_zero),
      .mem_ready (mem_ready),
      .mem_rd    (mem_rd),
      .ir_load   (ir_load),
      .pc_inc    (pc_inc),
      .pc_load   (pc_load),
      .ac_load   (ac_load),
      .ac_inc    (ac_inc),
      .ac_clr    (ac_clr),
      .halted    (halted),
      .fault     (fault),
      .state     (state),
      .instr_cnt (instr_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: sim time limit reached, bad=%0d", bad);
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] strb();
      return {mem_rd, ir_load, pc_inc, pc_load, ac_load, ac_inc, ac_clr};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      start     = 1'b0;
      mem_ready = 1'b0;
      ac_zero   = 1'b0;
      ir_opcode = 4'h0;
      tick();
      rst = 1'b0;
   endtask

   task automatic start_run();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // From a FETCH cycle: fetch immediately, decode, execute; ends one cycle
   // after EXEC.
   task automatic exec_instr(input logic [3:0] op, input logic az, input logic [6:0] exp_exec);
      mem_ready = 1'b1;
      ir_opcode = op;
      ac_zero   = az;
      #1;
      chk("fetch_state", 32'(state), 32'd1);
      chk("fetch_strb", 32'(strb()), 32'(S_FETCH));
      tick();
      #1;
      chk("decode_state", 32'(state), 32'd2);
      chk("decode_strb", 32'(strb()), 32'(S_NONE));
      tick();
      #1;
      chk("exec_state", 32'(state), 32'd3);
      chk("exec_strb", 32'(strb()), 32'(exp_exec));
      tick();
   endtask

   initial begin
      rst       = 1'b0;
      start     = 1'b0;
      mem_ready = 1'b0;
      ac_zero   = 1'b0;
      ir_opcode = 4'h0;
      #2;

      // reset state
      do_reset();
      #1;
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_strb", 32'(strb()), 32'(S_NONE));
      chk("rst_cnt", 32'(instr_cnt), 32'd0);
      chk("rst_flags", 32'({halted, fault}), 32'd0);

      // LDA with immediate memory: fetch in cycle 1, ac_load in cycle 3
      start     = 1'b1;
      mem_ready = 1'b1;
      ir_opcode = 4'h1;
      #1;
      chk("idle_strb", 32'(strb()), 32'(S_NONE));
      tick();
      start = 1'b0;
      #1;
      chk("lda_c1_strb", 32'(strb()), 32'(S_FETCH));
      tick();
      #1;
      chk("lda_c2_strb", 32'(strb()), 32'(S_NONE));
      tick();
      #1;
      chk("lda_c3_strb", 32'(strb()), 32'(S_ACL));
      tick();
      chk("lda_cnt", 32'(instr_cnt), 32'd1);
      chk("lda_next", 32'(state), 32'd1);

      // JZ twice: taken, then not taken
      do_reset();
      start_run();
      exec_instr(4'h5, 1'b1, S_PCL);
      exec_instr(4'h5, 1'b0, S_NONE);
      chk("jz_cnt", 32'(instr_cnt), 32'd2);

      // remaining opcodes, then HLT and restart
      exec_instr(4'h3, 1'b0, S_ACI);
      exec_instr(4'h2, 1'b0, S_ACC);
      exec_instr(4'h0, 1'b0, S_NONE);
      exec_instr(4'h4, 1'b0, S_PCL);
      chk("mix_cnt", 32'(instr_cnt), 32'd6);
      exec_instr(4'hF, 1'b0, S_NONE);
      chk("hlt_state", 32'(state), 32'd4);
      chk("hlt_halted", 32'(halted), 32'd1);
      chk("hlt_cnt", 32'(instr_cnt), 32'd7);
      mem_ready = 1'b0;
      tick();
      chk("hlt_hold", 32'(state), 32'd4);
      chk("hlt_strb", 32'(strb()), 32'(S_NONE));
      start_run();
      chk("resume_state", 32'(state), 32'd1);
      chk("resume_strb", 32'(strb()), 32'(S_WAIT));
      chk("resume_halted", 32'(halted), 32'd0);

      // fetch timeout: 16 cycles without mem_ready
      do_reset();
      start_run();
      for (int i = 0; i < 16; i++) begin
         chk("wait_state", 32'(state), 32'd1);
         chk("wait_strb", 32'(strb()), 32'(S_WAIT));
         tick();
      end
      chk("to_state", 32'(state), 32'd5);
      chk("to_fault", 32'(fault), 32'd1);
      start_run();
      chk("to_hold_state", 32'(state), 32'd5);
      chk("to_hold_fault", 32'(fault), 32'd1);
      chk("to_hold_strb", 32'(strb()), 32'(S_NONE));

      // ready on the last allowed wait cycle still fetches
      do_reset();
      start_run();
      for (int i = 0; i < 15; i++) begin
         tick();
      end
      chk("edge_wait_state", 32'(state), 32'd1);
      mem_ready = 1'b1;
      #1;
      chk("edge_fetch_strb", 32'(strb()), 32'(S_FETCH));
      tick();
      chk("edge_decode", 32'(state), 32'd2);

      // illegal opcode
      do_reset();
      start_run();
      exec_instr(4'h7, 1'b0, S_NONE);
      chk("ill_state", 32'(state), 32'd5);
      chk("ill_fault", 32'(fault), 32'd1);
      chk("ill_cnt", 32'(instr_cnt), 32'd0);
      do_reset();
      chk("ill_rst_state", 32'(state), 32'd0);
      chk("ill_rst_fault", 32'(fault), 32'd0);

      // reset during EXEC of INC
      start_run();
      mem_ready = 1'b1;
      ir_opcode = 4'h3;
      tick();
      tick();
      chk("inc_in_exec", 32'(state), 32'd3);
      rst = 1'b1;
      #1;
      chk("rst_exec_strb", 32'(strb()), 32'(S_NONE));
      tick();
      rst = 1'b0;
      #1;
      chk("rst_exec_state", 32'(state), 32'd0);
      chk("rst_exec_cnt", 32'(instr_cnt), 32'd0);
      chk("rst_exec_strb2", 32'(strb()), 32'(S_NONE));

      // reset during FETCH with mem_ready high
      start_run();
      rst = 1'b1;
      #1;
      chk("rst_fetch_strb", 32'(strb()), 32'(S_NONE));
      tick();
      rst = 1'b0;
      #1;
      chk("rst_fetch_state", 32'(state), 32'd0);
      chk("rst_fetch_strb2", 32'(strb()), 32'(S_NONE));

      // 256 NOPs wrap the retire counter
      do_reset();
      start_run();
      for (int i = 0; i < 255; i++) begin
         exec_instr(4'h0, 1'b0, S_NONE);
      end
      chk("nop_255", 32'(instr_cnt), 32'd255);
      exec_instr(4'h0, 1'b0, S_NONE);
      chk("nop_wrap", 32'(instr_cnt), 32'd0);
      chk("nop_state", 32'(state), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
